// File: rtl/operand_sequencer.sv
// Operand sequencer: calculator front-end FSM.
// Captures NUM_OPS keypad operands on ENTER, requests the ALU, shows the
// result, and lets the result be chained in as operand 0 of the next job.
module operand_sequencer #(
    parameter int DATA_W  = 40,
    parameter int NUM_OPS = 2,
    parameter int IDX_W   = 3
) (
    input  logic                        clk,
    input  logic                        reset_button,
    input  logic                        enter_button,
    input  logic                        clear_button,
    input  logic                        enable_switch,
    input  logic [DATA_W-1:0]           in_val,
    input  logic [DATA_W-1:0]           in_prev_res,
    input  logic                        res_valid,
    output logic                        op_req,
    output logic [NUM_OPS*DATA_W-1:0]   ops_flat,
    output logic [IDX_W-1:0]            op_idx,
    output logic [1:0]                  display_sel,
    output logic [3:0]                  led
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REQ     = 2'd1,
        SHOW    = 2'd2,
        CONT    = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    logic ent_s1_q, ent_s2_q, ent_prev_q;
    logic clr_s1_q, clr_s2_q, clr_prev_q;
    logic ent_p, clr_p;

    state_t                      state_q, state_d;
    logic [NUM_OPS*DATA_W-1:0]   ops_q, ops_d;
    logic [IDX_W-1:0]            op_idx_q, op_idx_d;
    logic                        op_req_q, op_req_d;
    logic [1:0]                  display_sel_q, display_sel_d;
    logic [3:0]                  led_q, led_d;

    // Two-flop synchronisers plus a history flop for rising-edge detection of the buttons.
    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            ent_s1_q   <= 1'b0;
            ent_s2_q   <= 1'b0;
            ent_prev_q <= 1'b0;
            clr_s1_q   <= 1'b0;
            clr_s2_q   <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            ent_s1_q   <= enter_button;
            ent_s2_q   <= ent_s1_q;
            ent_prev_q <= ent_s2_q;
            clr_s1_q   <= clear_button;
            clr_s2_q   <= clr_s1_q;
            clr_prev_q <= clr_s2_q;
        end
    end

    assign ent_p = ent_s2_q & ~ent_prev_q & enable_switch;
    assign clr_p = clr_s2_q & ~clr_prev_q;

    // Next-state logic; a clear pulse overrides every other event in every state.
    always_comb begin
        state_d       = state_q;
        ops_d         = ops_q;
        op_idx_d      = op_idx_q;
        op_req_d      = op_req_q;
        display_sel_d = display_sel_q;
        if (clr_p) begin
            state_d       = COLLECT;
            ops_d         = '0;
            op_idx_d      = '0;
            op_req_d      = 1'b0;
            display_sel_d = 2'b00;
        end else begin
            case (state_q)
                COLLECT, CONT: begin
                    if (ent_p) begin
                        for (int k = 0; k < NUM_OPS; k++) begin
                            if (op_idx_q == IDX_W'(k)) begin
                                ops_d[k*DATA_W +: DATA_W] = in_val;
                            end
                        end
                        if (op_idx_q == LAST_IDX) begin
                            state_d  = REQ;
                            op_req_d = 1'b1;
                        end else begin
                            op_idx_d      = op_idx_q + IDX_W'(1);
                            display_sel_d = 2'b01;
                        end
                    end
                end
                REQ: begin
                    if (op_req_q && res_valid) begin
                        state_d       = SHOW;
                        op_req_d      = 1'b0;
                        display_sel_d = 2'b11;
                    end
                end
                SHOW: begin
                    if (ent_p) begin
                        ops_d                 = '0;
                        ops_d[DATA_W-1:0]     = in_prev_res;
                        op_idx_d              = IDX_W'(1);
                        display_sel_d         = 2'b01;
                        state_d               = CONT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // One-hot LED pattern follows the state being entered so it is registered with it.
    always_comb begin
        led_d = 4'b0001;
        case (state_d)
            COLLECT: led_d = 4'b0001;
            REQ:     led_d = 4'b0010;
            SHOW:    led_d = 4'b0100;
            CONT:    led_d = 4'b1000;
            default: led_d = 4'b0001;
        endcase
    end

    // State and output registers; reset asserts immediately and releases on a clock.
    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            state_q       <= COLLECT;
            ops_q         <= '0;
            op_idx_q      <= '0;
            op_req_q      <= 1'b0;
            display_sel_q <= 2'b00;
            led_q         <= 4'b0001;
        end else begin
            state_q       <= state_d;
            ops_q         <= ops_d;
            op_idx_q      <= op_idx_d;
            op_req_q      <= op_req_d;
            display_sel_q <= display_sel_d;
            led_q         <= led_d;
        end
    end

    assign op_req      = op_req_q;
    assign ops_flat    = ops_q;
    assign op_idx      = op_idx_q;
    assign display_sel = display_sel_q;
    assign led         = led_q;

endmodule
